// File: rtl/score_pkg.sv
// Shared definitions for the BCD score keeper.
// Contents:
//   BCD_NINE / BCD_ZERO : digit limit constants
//   MAX_DIGITS          : widest score any instance supports
//   bcd_digit_t         : one packed BCD digit
//   bcd_gt(a, b)        : multi-digit BCD magnitude compare, MSD first
package score_pkg;

    localparam logic [3:0] BCD_NINE   = 4'd9;
    localparam logic [3:0] BCD_ZERO   = 4'd0;
    localparam int         MAX_DIGITS = 6;

    typedef logic [3:0] bcd_digit_t;

    // Operands are zero-extended to MAX_DIGITS digits by the caller. The
    // first differing digit, scanning from the most significant end, decides.
    function automatic logic bcd_gt(input logic [MAX_DIGITS*4-1:0] a,
                                    input logic [MAX_DIGITS*4-1:0] b);
        logic decided;
        logic result;
        decided = 1'b0;
        result  = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                decided = 1'b1;
                result  = (a[i*4 +: 4] > b[i*4 +: 4]);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// One player's NUM_DIGITS-digit BCD up/down counter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear of count and ovf (highest priority)
//   inc, dec  : +1 / -1 request (inc wins if both are set)
//   sat_mode  : 1 = hold at all-nines, 0 = wrap to zero on overflow
//   count     : packed BCD value, digit 0 in the low nibble
//   ovf       : sticky flag, set by a credit at all-nines
module bcd_counter
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    sat_mode,
    output logic [NUM_DIGITS*4-1:0] count,
    output logic                    ovf
);

    // nine_run[d] / zero_run[d]: every digit below d is 9 / 0. These are the
    // ripple carry and borrow into digit d.
    logic [NUM_DIGITS:0]     nine_run;
    logic [NUM_DIGITS:0]     zero_run;
    logic [NUM_DIGITS*4-1:0] inc_val;
    logic [NUM_DIGITS*4-1:0] dec_val;
    logic                    all_nines;
    logic                    all_zeros;

    assign nine_run[0] = 1'b1;
    assign zero_run[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_t digit;
            assign digit          = count[gi*4 +: 4];
            assign nine_run[gi+1] = nine_run[gi] & (digit == BCD_NINE);
            assign zero_run[gi+1] = zero_run[gi] & (digit == BCD_ZERO);
            assign inc_val[gi*4 +: 4] = !nine_run[gi] ? digit :
                                        (digit == BCD_NINE) ? BCD_ZERO : digit + 4'd1;
            assign dec_val[gi*4 +: 4] = !zero_run[gi] ? digit :
                                        (digit == BCD_ZERO) ? BCD_NINE : digit - 4'd1;

            a_digit_bcd : assert property (@(posedge clk) disable iff (rst)
                                           digit <= BCD_NINE);
        end
    endgenerate

    assign all_nines = nine_run[NUM_DIGITS];
    assign all_zeros = zero_run[NUM_DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (all_nines) begin
                ovf <= 1'b1;
                if (!sat_mode) begin
                    count <= '0;
                end
            end else begin
                count <= inc_val;
            end
        end else if (dec) begin
            // Floor at zero: no borrow out of the top digit.
            if (!all_zeros) begin
                count <= dec_val;
            end
        end
    end

endmodule

// File: rtl/bcd_score_keeper.sv
// Multi-player BCD score keeper with persistent high-score tracking.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   score_reset    : synchronous clear of all scores and overflow flags
//   hs_clear       : synchronous clear of high_score / high_player
//   verify_out     : event strobe; event_player selects the player,
//                    event_penalty selects -1 (1) or +1 (0)
//   score_out      : player p digit d at [(p*NUM_DIGITS+d)*4 +: 4]
//   overflow       : sticky per-player overflow flags
//   high_score     : best score since rst/hs_clear, BCD
//   high_player    : index of the high-score holder
//   hs_update      : one-cycle pulse when a new high score is loaded
module bcd_score_keeper
    import score_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int NUM_PLAYERS = 2,
    parameter int SAT_MODE    = 1,
    parameter int PLAYER_W    = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                score_reset,
    input  logic                                hs_clear,
    input  logic                                verify_out,
    input  logic [PLAYER_W-1:0]                 event_player,
    input  logic                                event_penalty,
    output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] score_out,
    output logic [NUM_PLAYERS-1:0]              overflow,
    output logic [NUM_DIGITS*4-1:0]             high_score,
    output logic [PLAYER_W-1:0]                 high_player,
    output logic                                hs_update
);

    localparam int                SW           = NUM_DIGITS * 4;
    localparam logic [PLAYER_W:0] PLAYER_LIMIT = (PLAYER_W+1)'(NUM_PLAYERS);
    localparam logic              SAT_BIT      = (SAT_MODE != 0);

    logic                   event_valid;
    logic [NUM_PLAYERS-1:0] inc_vec;
    logic [NUM_PLAYERS-1:0] dec_vec;

    // Out-of-range player indices are dropped here so no counter sees them.
    assign event_valid = verify_out && ({1'b0, event_player} < PLAYER_LIMIT);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic sel;
            assign sel         = event_valid && (event_player == PLAYER_W'(gi));
            assign inc_vec[gi] = sel && !event_penalty;
            assign dec_vec[gi] = sel && event_penalty;

            bcd_counter #(
                .NUM_DIGITS (NUM_DIGITS)
            ) u_counter (
                .clk      (clk),
                .rst      (rst),
                .clr      (score_reset),
                .inc      (inc_vec[gi]),
                .dec      (dec_vec[gi]),
                .sat_mode (SAT_BIT),
                .count    (score_out[gi*SW +: SW]),
                .ovf      (overflow[gi])
            );
        end
    endgenerate

    // Lowest-index player strictly above the current high score. Works on
    // the registered scores, so the tracker trails score_out by one cycle.
    logic                    found;
    logic [PLAYER_W-1:0]     win_player;
    logic [SW-1:0]           win_score;
    logic [MAX_DIGITS*4-1:0] cand_ext;
    logic [MAX_DIGITS*4-1:0] hs_ext;

    always_comb begin
        found      = 1'b0;
        win_player = '0;
        win_score  = '0;
        cand_ext   = '0;
        hs_ext     = '0;
        hs_ext[SW-1:0] = high_score;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            cand_ext          = '0;
            cand_ext[SW-1:0]  = score_out[p*SW +: SW];
            if (!found && bcd_gt(cand_ext, hs_ext)) begin
                found      = 1'b1;
                win_player = PLAYER_W'(p);
                win_score  = score_out[p*SW +: SW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_score  <= '0;
            high_player <= '0;
            hs_update   <= 1'b0;
        end else begin
            hs_update <= 1'b0;
            // A clear overrides a simultaneous new high; the winner is
            // re-found next cycle against the zeroed value.
            if (hs_clear) begin
                high_score  <= '0;
                high_player <= '0;
            end else if (found) begin
                high_score  <= win_score;
                high_player <= win_player;
                hs_update   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bcd_score_keeper.md
Name: bcd_score_keeper

Overview:
- Parametrised successor to the two-digit single-player score board.
- Keeps one N-digit BCD score per player and accepts credit and penalty events from the answer-verification logic.
- Tracks a persistent high score and its holder.
- Drives the seven-segment display mux and the game controller.

Parameters:
- NUM_DIGITS, 2: BCD digits per player score, 1..6.
- NUM_PLAYERS, 2: independent player scores, 1..8.
- SAT_MODE, 1: 1 = score saturates at all-nines; 0 = score wraps to zero.
- PLAYER_W, 3: width of the player index; must satisfy 2^PLAYER_W >= NUM_PLAYERS.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- score_reset  in  1  synchronous clear of all player scores and overflow flags.
- hs_clear  in  1  synchronous clear of the high score and its holder.
- verify_out  in  1  one-cycle event strobe; 1 = apply an event this cycle.
- event_player  in  PLAYER_W  player index the event applies to.
- event_penalty  in  1  0 = credit (+1), 1 = penalty (-1).
- score_out  out  NUM_PLAYERS*NUM_DIGITS*4  flattened BCD scores; player p digit d at bits [(p*NUM_DIGITS+d)*4 +: 4]; digit 0 is least significant.
- overflow  out  NUM_PLAYERS  sticky per-player flag; set when a credit hits all-nines.
- high_score  out  NUM_DIGITS*4  highest score reached since the last rst/hs_clear, in BCD.
- high_player  out  PLAYER_W  index of the high-score holder.
- hs_update  out  1  one-cycle pulse when high_score changes.

Behaviour:
- rst = 1 (async) forces all outputs and all internal state to zero.
- Priority on each clock edge: score_reset > verify_out. hs_clear is independent of score_reset; both may act on the same edge.
- Event latency: a verify_out sampled at edge k appears on score_out after edge k.
- Events with event_player >= NUM_PLAYERS are ignored; no state changes.
- Credit: BCD increment with ripple carry. A digit at 9 goes to 0 and carries into the next digit.
- Credit when the score is all-nines:
  - SAT_MODE=1: score holds.
  - SAT_MODE=0: score wraps to all-zeros.
  - In both modes overflow[p] is set and stays set until score_reset or rst.
- Penalty: BCD decrement with ripple borrow. A digit at 0 goes to 9 and borrows from the next digit.
- Penalty at all-zeros holds at zero (floor). No flag is set.
- Only one event is accepted per cycle. Back-to-back verify_out every cycle must count every pulse.
- Digits never leave the range 0..9. Non-BCD values are unreachable and are covered by assertion.
- High-score tracker:
  - Compares registered scores, so it lags score_out by one cycle (two edges after the event).
  - A player's score strictly greater than high_score loads high_score and high_player and pulses hs_update for one cycle.
  - On equal scores the current holder is kept.
  - If several players exceed high_score in the same cycle, the lowest index wins.
- score_reset does not clear high_score; only rst or hs_clear do.
- If hs_clear and a new high score land on the same edge, hs_clear wins. The tracker re-evaluates on the next cycle against the zeroed high score.
- Penalties never reduce high_score.

Decomposition:
- Shared package score_pkg:
  - Constants BCD_NINE = 4'd9 and BCD_ZERO = 4'd0.
  - Typedef bcd_digit_t (4-bit).
  - Function bcd_gt(a, b), multi-digit magnitude compare, most significant digit first.
- Sub-module bcd_counter: one player's NUM_DIGITS chain with inc, dec, clr and sat_mode inputs, the count output and an ovf output.
  - Instantiated NUM_PLAYERS times with a generate loop.
  - The top level holds the event decode and the high-score tracker.

Test Plan (NUM_DIGITS=2, NUM_PLAYERS=2, SAT_MODE=1 unless noted):
- Carry: 10 credits to player 0 → score_out[7:0]=8'h10; 99 credits → 8'h99, overflow[0]=0; 100th credit → stays 8'h99, overflow[0]=1.
- Wrap: with SAT_MODE=0, 100 credits → 8'h00 and overflow[0]=1; the next credit → 8'h01.
- Penalty: player 1 at 8'h10, one penalty → 8'h09; at 8'h00 a penalty → stays 8'h00.
- High score:
  - p0 reaches 8'h05 → high_score=8'h05, high_player=0, one hs_update pulse.
  - p1 reaches 8'h05 → no change.
  - p1 reaches 8'h06 → high_player=1.
  - Then score_reset → scores 0, high_score still 8'h06.
- Priority and range: score_reset and verify_out together → score 0. event_player=3 → no change. hs_clear → high_score=0, high_player=0.
- Async reset: assert rst between clock edges with non-zero state → all outputs 0 immediately. Deassert, then one credit → 8'h01 one edge later.
